dnn_stream_tx: RTL and testbench

Host-side transmitter for the accelerator's `src` stream. It buffers words pushed by the host in an internal FIFO. On `start` it emits exactly `len` beats on `src_valid`/`src_data`/`src_last` under `src_ready` back-pressure. It sits between the host/test harness and `tiny_dnn_top`'s `src_*` port, and is the producer for weight, bias and input-data loads.

---
 rtl/dnn_stream_pkg.sv | 15 +
 rtl/dnn_stream_tx_if.sv | 14 +
 rtl/dnn_sync_fifo.sv | 60 ++++++
 rtl/dnn_stream_tx.sv | 118 +++++++++++
 tb/tb_dnn_stream_tx.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dnn_stream_pkg.sv
// Shared types and default sizes for the host-side stream transmitter.
// Imported by the interface, the FIFO wrapper top and the testbench.
package dnn_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_t;

    localparam int DNN_TX_DEPTH = 64;
    localparam int DNN_LEN_W    = 12;
    localparam int DNN_DATA_W   = 32;

endpackage

// File: rtl/dnn_stream_tx_if.sv
// Valid/ready beat stream toward the accelerator src port; master drives valid/data/last.
// The sink applies back-pressure through ready only.
interface dnn_stream_tx_if;
    import dnn_stream_pkg::*;

    logic                  valid;
    logic [DNN_DATA_W-1:0] data;
    logic                  last;
    logic                  ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/dnn_sync_fifo.sv
// Synchronous FIFO, head word readable straight from storage; count/full registered.
// Pushes while full are dropped; pops while empty are ignored; push+pop both happen.
module dnn_sync_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers wrap naturally at AW bits; occupancy disambiguates full/empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dnn_stream_tx.sv
// Host transmitter: buffers host words, emits len beats from a registered output stage (start->valid 1 cycle).
// Output holds under !ready; DNN_TX_PACK16_EN splits each word into two 16-bit beats.
module dnn_stream_tx
    import dnn_stream_pkg::*;
#(
    parameter int DEPTH = DNN_TX_DEPTH,
    parameter int LEN_W = DNN_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   host_push,
    input  logic [31:0]            host_data,
    output logic                   host_full,
    output logic [$clog2(DEPTH):0] host_count,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    output logic                   busy,
    output logic                   done,
    dnn_stream_tx_if.master        src
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_SEND = 2'(SEND);
    localparam logic [1:0] S_DONE = 2'(DONE);

    logic [1:0]       state;
    logic [LEN_W-1:0] remain;
    logic [LEN_W-1:0] issue;
    logic [LEN_W-1:0] issue_cur;
    logic             out_vld;
    logic [31:0]      out_dat;
    logic [31:0]      load_dat;
    logic [31:0]      fifo_rdata;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             start_ok;
    logic             accept;
    logic             can_load;

    dnn_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (host_push),
        .wdata (host_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (host_full),
        .empty (fifo_empty),
        .count (host_count)
    );

    assign start_ok  = (state == S_IDLE) & start & (len != '0);
    assign accept    = out_vld & src.ready;
    // issue counts beats not yet loaded into the output stage; remain counts beats not yet accepted.
    assign issue_cur = start_ok ? len : issue;
    assign can_load  = (start_ok | (state == S_SEND)) & (issue_cur != '0)
                     & ~fifo_empty & (~out_vld | accept);

`ifdef DNN_TX_PACK16_EN
    logic half;

    assign load_dat = half ? {fifo_rdata[15:0], 16'h0000} : {fifo_rdata[31:16], 16'h0000};
    assign fifo_pop = can_load & (half | (issue_cur == LEN_W'(1)));

    always_ff @(posedge clk) begin
        if (rst)           half <= 1'b0;
        else if (can_load) half <= ~fifo_pop;
    end
`else
    assign load_dat = fifo_rdata;
    assign fifo_pop = can_load;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            remain  <= '0;
            issue   <= '0;
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state  <= S_SEND;
                            remain <= len;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_SEND: begin
                    if (accept) begin
                        remain <= remain - LEN_W'(1);
                        if (remain == LEN_W'(1)) state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (start_ok | can_load) issue <= issue_cur - LEN_W'(can_load);

            if (can_load)    out_vld <= 1'b1;
            else if (accept) out_vld <= 1'b0;

            if (can_load) out_dat <= load_dat;
        end
    end

    assign busy      = (state == S_SEND);
    assign done      = (state == S_DONE);
    assign src.valid = out_vld;
    assign src.data  = out_dat;
    assign src.last  = out_vld & (remain == LEN_W'(1));

endmodule

// File: tb/tb_dnn_stream_tx.sv
// Directed bench for dnn_stream_tx: inputs driven 1ns after the rising edge, outputs sampled there too.
module tb_dnn_stream_tx;
    import dnn_stream_pkg::*;

    logic        clk;
    logic        rst;
    logic        host_push;
    logic [31:0] host_data;
    logic        host_full;
    logic [6:0]  host_count;
    logic        start;
    logic [11:0] len;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    dnn_stream_tx_if src_if ();

    dnn_stream_tx #(.DEPTH(64), .LEN_W(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .host_push  (host_push),
        .host_data  (host_data),
        .host_full  (host_full),
        .host_count (host_count),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .src        (src_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; host_push = 1'b0; start = 1'b0; len = '0; src_if.ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push_word(input logic [31:0] w);
        host_push = 1'b1;
        host_data = w;
        tick();
        host_push = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; host_push = 1'b0; host_data = '0; start = 1'b0; len = '0; src_if.ready = 1'b0;
        tick();
        tick();
        checks++;
        if (src_if.valid !== 1'b0 || src_if.last !== 1'b0 || src_if.data !== 32'h0) begin
            failures++;
            $display("FAIL reset_src valid=%b last=%b data=%h want 0/0/0", src_if.valid, src_if.last, src_if.data);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || host_full !== 1'b0 || host_count !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctl busy=%b done=%b full=%b count=%0d want 0/0/0/0", busy, done, host_full, host_count);
        end
        rst = 1'b0;
        src_if.ready = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) push_word(32'(i + 1) << 16);
        checks++;
        if (host_count !== 7'd4) begin
            failures++;
            $display("FAIL basic_count got=%0d want=4", host_count);
        end
        start = 1'b1; len = 12'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (src_if.valid !== 1'b1 || src_if.data !== (32'(k + 1) << 16) || src_if.last !== (k == 3)) begin
                failures++;
                $display("FAIL basic_beat%0d valid=%b data=%h last=%b want 1/%h/%b",
                         k, src_if.valid, src_if.data, src_if.last, 32'(k + 1) << 16, k == 3);
            end
            if (k == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_busy got=%b want=1", busy);
                end
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || src_if.valid !== 1'b0 || host_count !== 7'd0) begin
            failures++;
            $display("FAIL basic_done done=%b busy=%b valid=%b count=%0d want 1/0/0/0", done, busy, src_if.valid, host_count);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got=%b want=0", done);
        end
    endtask

    task automatic test_backpressure();
        logic        pat [4];
        logic        stalled;
        logic        saw_done;
        logic [31:0] pdata;
        logic        plast;
        int          hs;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int i = 0; i < 4; i++) push_word(32'(i + 5) << 16);
        start = 1'b1; len = 12'd4;
        tick();
        start = 1'b0;
        hs = 0; stalled = 1'b0; saw_done = 1'b0; pdata = '0; plast = 1'b0;
        for (int c = 0; c < 40 && !saw_done; c++) begin
            if (stalled) begin
                checks++;
                if (src_if.valid !== 1'b1 || src_if.data !== pdata || src_if.last !== plast) begin
                    failures++;
                    $display("FAIL bp_hold valid=%b data=%h last=%b want 1/%h/%b", src_if.valid, src_if.data, src_if.last, pdata, plast);
                end
            end
            if (done === 1'b1) begin
                saw_done = 1'b1;
            end else begin
                src_if.ready = pat[c % 4];
                if (src_if.valid === 1'b1 && src_if.ready === 1'b1) begin
                    checks++;
                    if (src_if.data !== (32'(hs + 5) << 16) || src_if.last !== (hs == 3)) begin
                        failures++;
                        $display("FAIL bp_beat%0d data=%h last=%b want %h/%b", hs, src_if.data, src_if.last, 32'(hs + 5) << 16, hs == 3);
                    end
                    hs++;
                end
                stalled = src_if.valid & ~src_if.ready;
                pdata   = src_if.data;
                plast   = src_if.last;
                tick();
            end
        end
        src_if.ready = 1'b1;
        checks++;
        if (hs != 4 || !saw_done) begin
            failures++;
            $display("FAIL bp_handshakes got=%0d done_seen=%b want 4/1", hs, saw_done);
        end
        tick();
    endtask

    task automatic test_underrun();
        push_word(32'h1111_0000);
        start = 1'b1; len = 12'd3;
        tick();
        start = 1'b0;
        checks++;
        if (src_if.valid !== 1'b1 || src_if.data !== 32'h1111_0000 || src_if.last !== 1'b0) begin
            failures++;
            $display("FAIL ur_first valid=%b data=%h last=%b want 1/11110000/0", src_if.valid, src_if.data, src_if.last);
        end
        tick();
        checks++;
        if (src_if.valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ur_stall valid=%b busy=%b want 0/1", src_if.valid, busy);
        end
        tick();
        host_push = 1'b1; host_data = 32'h2222_0000;
        tick();
        checks++;
        if (src_if.valid !== 1'b0) begin
            failures++;
            $display("FAIL ur_push_lat1 valid=%b want 0", src_if.valid);
        end
        host_data = 32'h3333_0000;
        tick();
        host_push = 1'b0;
        checks++;
        if (src_if.valid !== 1'b1 || src_if.data !== 32'h2222_0000 || src_if.last !== 1'b0) begin
            failures++;
            $display("FAIL ur_second valid=%b data=%h last=%b want 1/22220000/0", src_if.valid, src_if.data, src_if.last);
        end
        tick();
        checks++;
        if (src_if.valid !== 1'b1 || src_if.data !== 32'h3333_0000 || src_if.last !== 1'b1) begin
            failures++;
            $display("FAIL ur_third valid=%b data=%h last=%b want 1/33330000/1", src_if.valid, src_if.data, src_if.last);
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL ur_done got=%b want=1", done);
        end
        tick();
    endtask

    task automatic test_full();
        for (int i = 0; i < 65; i++) push_word(32'hC000_0000 | 32'(i));
        checks++;
        if (host_full !== 1'b1 || host_count !== 7'd64) begin
            failures++;
            $display("FAIL full_flag full=%b count=%0d want 1/64", host_full, host_count);
        end
        start = 1'b1; len = 12'd64;
        tick();
        start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            checks++;
            if (src_if.valid !== 1'b1 || src_if.data !== (32'hC000_0000 | 32'(k)) || src_if.last !== (k == 63)) begin
                failures++;
                $display("FAIL full_drain%0d valid=%b data=%h last=%b want 1/%h/%b",
                         k, src_if.valid, src_if.data, src_if.last, 32'hC000_0000 | 32'(k), k == 63);
            end
            tick();
        end
        checks++;
        if (done !== 1'b1 || host_full !== 1'b0 || host_count !== 7'd0) begin
            failures++;
            $display("FAIL full_after done=%b full=%b count=%0d want 1/0/0", done, host_full, host_count);
        end
        tick();
    endtask

    task automatic test_len0();
        push_word(32'h0BAD_0000);
        start = 1'b1; len = 12'd0;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || src_if.valid !== 1'b0 || host_count !== 7'd1) begin
            failures++;
            $display("FAIL len0_done done=%b busy=%b valid=%b count=%0d want 1/0/0/1", done, busy, src_if.valid, host_count);
        end
        tick();
        checks++;
        if (done !== 1'b0 || src_if.valid !== 1'b0) begin
            failures++;
            $display("FAIL len0_after done=%b valid=%b want 0/0", done, src_if.valid);
        end
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        do_reset();
        for (int i = 0; i < 5; i++) push_word(32'h5000_0000 | 32'(i));
        start = 1'b1; len = 12'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (src_if.valid !== 1'b0 || busy !== 1'b0 || host_count !== 7'd0 || src_if.last !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_state valid=%b busy=%b count=%0d last=%b want 0/0/0/0", src_if.valid, busy, host_count, src_if.last);
        end
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL rstmid_done got=1 want=0");
        end
    endtask

`ifdef DNN_TX_PACK16_EN
    task automatic test_pack16();
        push_word(32'hAAAA_BBBB);
        start = 1'b1; len = 12'd2;
        tick();
        start = 1'b0;
        checks++;
        if (src_if.valid !== 1'b1 || src_if.data !== 32'hAAAA_0000 || src_if.last !== 1'b0) begin
            failures++;
            $display("FAIL pack_hi valid=%b data=%h last=%b want 1/aaaa0000/0", src_if.valid, src_if.data, src_if.last);
        end
        tick();
        checks++;
        if (src_if.valid !== 1'b1 || src_if.data !== 32'hBBBB_0000 || src_if.last !== 1'b1) begin
            failures++;
            $display("FAIL pack_lo valid=%b data=%h last=%b want 1/bbbb0000/1", src_if.valid, src_if.data, src_if.last);
        end
        tick();
        checks++;
        if (done !== 1'b1 || host_count !== 7'd0) begin
            failures++;
            $display("FAIL pack_done done=%b count=%0d want 1/0", done, host_count);
        end
        tick();
        push_word(32'hAAAA_BBBB);
        start = 1'b1; len = 12'd1;
        tick();
        start = 1'b0;
        checks++;
        if (src_if.valid !== 1'b1 || src_if.data !== 32'hAAAA_0000 || src_if.last !== 1'b1) begin
            failures++;
            $display("FAIL pack_odd valid=%b data=%h last=%b want 1/aaaa0000/1", src_if.valid, src_if.data, src_if.last);
        end
        tick();
        checks++;
        if (done !== 1'b1 || host_count !== 7'd0 || src_if.valid !== 1'b0) begin
            failures++;
            $display("FAIL pack_odd_pop done=%b count=%0d valid=%b want 1/0/0", done, host_count, src_if.valid);
        end
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
`ifdef DNN_TX_PACK16_EN
        test_pack16();
`else
        test_basic();
        test_backpressure();
        test_underrun();
        test_full();
`endif
        test_len0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
